// File: rtl/rs_bank.sv
//------------------------------------------------------------------------------
// rs_bank: four-entry reservation station with CDB wakeup and scheduler free.
// Optional macro RS_DISPATCH_BYPASS_EN lets a dispatching operand capture a same-cycle CDB hit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rs_bank_pkg;
   localparam int RS_XLEN  = 32;
   localparam int RS_TAG_W = 4;

   typedef struct packed {
      logic                valid_operands;
      logic [2:0]          ALU_op;
      logic [1:0]          branch_type;
      logic [RS_TAG_W-1:0] ROB_entry;
      logic [RS_XLEN-1:0]  rs1;
      logic [RS_XLEN-1:0]  rs2;
   } rs_out_t;
endpackage

module rs_bank #(
   parameter int XLEN  = rs_bank_pkg::RS_XLEN,
   parameter int TAG_W = rs_bank_pkg::RS_TAG_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 disp_valid,
   output logic                 disp_ready,
   input  logic [2:0]           disp_alu_op,
   input  logic [1:0]           disp_branch_type,
   input  logic [TAG_W-1:0]     disp_rob_entry,
   input  logic                 disp_rs1_rdy,
   input  logic                 disp_rs2_rdy,
   input  logic [XLEN-1:0]      disp_rs1_val,
   input  logic [XLEN-1:0]      disp_rs2_val,
   input  logic [TAG_W-1:0]     disp_rs1_tag,
   input  logic [TAG_W-1:0]     disp_rs2_tag,
   input  logic                 cdb_valid,
   input  logic [TAG_W-1:0]     cdb_tag,
   input  logic [XLEN-1:0]      cdb_value,
   input  logic [3:0]           consumed_bus,
   output rs_bank_pkg::rs_out_t rs0_data,
   output rs_bank_pkg::rs_out_t rs1_data,
   output rs_bank_pkg::rs_out_t rs2_data,
   output rs_bank_pkg::rs_out_t rs3_data,
   output logic [2:0]           occupancy
);

   logic [3:0]       busy;
   logic [3:0]       busy_nxt;
   logic [3:0]       alloc_oh;
   logic [3:0]       load;
   logic [3:0]       wake1;
   logic [3:0]       wake2;
   logic             accept;
   logic             clear;
   logic [2:0]       alu_op_q [4];
   logic [1:0]       br_q     [4];
   logic [TAG_W-1:0] rob_q    [4];
   logic [3:0]       rdy1;
   logic [3:0]       rdy2;
   logic [XLEN-1:0]  val1     [4];
   logic [XLEN-1:0]  val2     [4];
   logic [TAG_W-1:0] tag1     [4];
   logic [TAG_W-1:0] tag2     [4];
   logic             d1_rdy;
   logic             d2_rdy;
   logic [XLEN-1:0]  d1_val;
   logic [XLEN-1:0]  d2_val;
   rs_bank_pkg::rs_out_t ent_out [4];

   assign clear      = reset | flush;
   assign disp_ready = ~&busy;
   assign accept     = disp_valid & disp_ready;
   // ~b & (b+1) isolates the lowest clear bit of busy.
   assign alloc_oh   = ~busy & (busy + 4'd1);
   assign load       = alloc_oh & {4{accept}};

`ifdef RS_DISPATCH_BYPASS_EN
   logic d1_hit;
   logic d2_hit;
   assign d1_hit = ~disp_rs1_rdy & cdb_valid & (cdb_tag == disp_rs1_tag);
   assign d2_hit = ~disp_rs2_rdy & cdb_valid & (cdb_tag == disp_rs2_tag);
   assign d1_rdy = disp_rs1_rdy | d1_hit;
   assign d2_rdy = disp_rs2_rdy | d2_hit;
   assign d1_val = disp_rs1_rdy ? disp_rs1_val : (d1_hit ? cdb_value : '0);
   assign d2_val = disp_rs2_rdy ? disp_rs2_val : (d2_hit ? cdb_value : '0);
`else
   assign d1_rdy = disp_rs1_rdy;
   assign d2_rdy = disp_rs2_rdy;
   assign d1_val = disp_rs1_rdy ? disp_rs1_val : '0;
   assign d2_val = disp_rs2_rdy ? disp_rs2_val : '0;
`endif

   always_comb begin
      wake1 = '0;
      wake2 = '0;
      for (int i = 0; i < 4; i++) begin
         wake1[i] = busy[i] & ~rdy1[i] & cdb_valid & (cdb_tag == tag1[i]);
         wake2[i] = busy[i] & ~rdy2[i] & cdb_valid & (cdb_tag == tag2[i]);
      end
      busy_nxt = clear ? 4'd0 : ((busy & ~consumed_bus) | load);
   end

   always_ff @(posedge clk) begin
      busy      <= busy_nxt;
      occupancy <= {2'b0, busy_nxt[0]} + {2'b0, busy_nxt[1]}
                 + {2'b0, busy_nxt[2]} + {2'b0, busy_nxt[3]};
      for (int i = 0; i < 4; i++) begin
         if (clear) begin
            alu_op_q[i] <= '0;
            br_q[i]     <= '0;
            rob_q[i]    <= '0;
            rdy1[i]     <= 1'b0;
            rdy2[i]     <= 1'b0;
            val1[i]     <= '0;
            val2[i]     <= '0;
            tag1[i]     <= '0;
            tag2[i]     <= '0;
         end else if (load[i]) begin
            alu_op_q[i] <= disp_alu_op;
            br_q[i]     <= disp_branch_type;
            rob_q[i]    <= disp_rob_entry;
            rdy1[i]     <= d1_rdy;
            rdy2[i]     <= d2_rdy;
            val1[i]     <= d1_val;
            val2[i]     <= d2_val;
            tag1[i]     <= disp_rs1_tag;
            tag2[i]     <= disp_rs2_tag;
         end else if (!consumed_bus[i]) begin
            // A consumed entry is leaving, so its wakeup is dropped.
            if (wake1[i]) begin
               rdy1[i] <= 1'b1;
               val1[i] <= cdb_value;
            end
            if (wake2[i]) begin
               rdy2[i] <= 1'b1;
               val2[i] <= cdb_value;
            end
         end
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_out
      assign ent_out[i] = busy[i] ?
         '{valid_operands: rdy1[i] & rdy2[i] & ~consumed_bus[i],
           ALU_op:         alu_op_q[i],
           branch_type:    br_q[i],
           ROB_entry:      rob_q[i],
           rs1:            val1[i],
           rs2:            val2[i]} : '0;
   end

   assign rs0_data = ent_out[0];
   assign rs1_data = ent_out[1];
   assign rs2_data = ent_out[2];
   assign rs3_data = ent_out[3];

endmodule

`default_nettype wire

// File: tb/tb_rs_bank.sv
// tb_rs_bank: directed plus randomized checking of rs_bank against an entry-list model.
`default_nettype none

module tb_rs_bank;
   logic        clk = 1'b0;
   logic        reset, flush, disp_valid, disp_ready;
   logic [2:0]  disp_alu_op;
   logic [1:0]  disp_branch_type;
   logic [3:0]  disp_rob_entry, disp_rs1_tag, disp_rs2_tag, cdb_tag, consumed_bus;
   logic        disp_rs1_rdy, disp_rs2_rdy, cdb_valid;
   logic [31:0] disp_rs1_val, disp_rs2_val, cdb_value;
   logic [2:0]  occupancy;
   rs_bank_pkg::rs_out_t rs0_data, rs1_data, rs2_data, rs3_data;
   rs_bank_pkg::rs_out_t outs [4];

   int passed = 0;
   int total  = 0;
   bit check_en = 0;

   // Reference model: one record per slot.
   bit          m_busy [4];
   bit          m_r1 [4], m_r2 [4];
   logic [2:0]  m_alu [4];
   logic [1:0]  m_br [4];
   logic [3:0]  m_rob [4], m_t1 [4], m_t2 [4];
   logic [31:0] m_v1 [4], m_v2 [4];
   int          m_occ = 0;

`ifdef RS_DISPATCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   rs_bank dut (
      .clk(clk), .reset(reset), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_alu_op(disp_alu_op), .disp_branch_type(disp_branch_type),
      .disp_rob_entry(disp_rob_entry),
      .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
      .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
      .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .consumed_bus(consumed_bus),
      .rs0_data(rs0_data), .rs1_data(rs1_data), .rs2_data(rs2_data), .rs3_data(rs3_data),
      .occupancy(occupancy)
   );

   assign outs[0] = rs0_data;
   assign outs[1] = rs1_data;
   assign outs[2] = rs2_data;
   assign outs[3] = rs3_data;

   always #5 clk = ~clk;

   // Model update: apply the cycle's inputs at each rising edge.
   always @(posedge clk) begin
      if (reset || flush) begin
         for (int i = 0; i < 4; i++) begin
            m_busy[i] = 0; m_r1[i] = 0; m_r2[i] = 0;
         end
      end else begin
         int fi;
         fi = -1;
         for (int i = 0; i < 4; i++) if (!m_busy[i] && fi < 0) fi = i;
         for (int i = 0; i < 4; i++) begin
            if (m_busy[i]) begin
               if (consumed_bus[i]) m_busy[i] = 0;
               else begin
                  if (!m_r1[i] && cdb_valid && cdb_tag == m_t1[i]) begin m_r1[i] = 1; m_v1[i] = cdb_value; end
                  if (!m_r2[i] && cdb_valid && cdb_tag == m_t2[i]) begin m_r2[i] = 1; m_v2[i] = cdb_value; end
               end
            end
         end
         if (disp_valid && fi >= 0) begin
            m_busy[fi] = 1;
            m_alu[fi] = disp_alu_op; m_br[fi] = disp_branch_type; m_rob[fi] = disp_rob_entry;
            m_t1[fi] = disp_rs1_tag; m_t2[fi] = disp_rs2_tag;
            m_r1[fi] = disp_rs1_rdy; m_v1[fi] = disp_rs1_val;
            m_r2[fi] = disp_rs2_rdy; m_v2[fi] = disp_rs2_val;
            if (BYP && !disp_rs1_rdy && cdb_valid && cdb_tag == disp_rs1_tag) begin m_r1[fi] = 1; m_v1[fi] = cdb_value; end
            if (BYP && !disp_rs2_rdy && cdb_valid && cdb_tag == disp_rs2_tag) begin m_r2[fi] = 1; m_v2[fi] = cdb_value; end
         end
      end
      m_occ = 0;
      for (int i = 0; i < 4; i++) m_occ += int'(m_busy[i]);
   end

   // Compare process: checks every output against the model mid-cycle.
   always @(negedge clk) begin
      if (check_en) begin
         total++;
         if (occupancy == 3'(m_occ) && disp_ready == (m_occ != 4)) passed++;
         else $display("FAIL occ_ready: occupancy=%0d ready=%0b, required %0d/%0b",
                       occupancy, disp_ready, m_occ, m_occ != 4);
         for (int i = 0; i < 4; i++) begin
            bit ok;
            if (!m_busy[i]) ok = (outs[i] == '0);
            else begin
               ok = outs[i].valid_operands == (m_r1[i] & m_r2[i] & ~consumed_bus[i])
                  && outs[i].ALU_op == m_alu[i] && outs[i].branch_type == m_br[i]
                  && outs[i].ROB_entry == m_rob[i]
                  && (!m_r1[i] || outs[i].rs1 == m_v1[i])
                  && (!m_r2[i] || outs[i].rs2 == m_v2[i]);
            end
            total++;
            if (ok) passed++;
            else $display("FAIL entry%0d: got v=%0b op=%0d br=%0d rob=%0d rs1=%h rs2=%h, required busy=%0b v=%0b op=%0d br=%0d rob=%0d rs1=%h rs2=%h",
                          i, outs[i].valid_operands, outs[i].ALU_op, outs[i].branch_type,
                          outs[i].ROB_entry, outs[i].rs1, outs[i].rs2, m_busy[i],
                          m_r1[i] & m_r2[i] & ~consumed_bus[i], m_alu[i], m_br[i], m_rob[i], m_v1[i], m_v2[i]);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 0; disp_valid = 0; cdb_valid = 0; consumed_bus = 4'd0;
   endtask

   task automatic disp(input logic [2:0] alu, input logic [3:0] rob,
                       input bit r1, input logic [31:0] v1, input logic [3:0] t1,
                       input bit r2, input logic [31:0] v2, input logic [3:0] t2);
      disp_valid = 1; disp_alu_op = alu; disp_rob_entry = rob; disp_branch_type = rob[1:0];
      disp_rs1_rdy = r1; disp_rs1_val = v1; disp_rs1_tag = t1;
      disp_rs2_rdy = r2; disp_rs2_val = v2; disp_rs2_tag = t2;
   endtask

   task automatic cdb(input logic [3:0] t, input logic [31:0] v);
      cdb_valid = 1; cdb_tag = t; cdb_value = v;
   endtask

   initial begin
      reset = 1; idle();
      disp(3'd0, 4'd0, 0, 32'd0, 4'd0, 0, 32'd0, 4'd0);
      disp_valid = 0; cdb_tag = 0; cdb_value = 0;
      repeat (3) @(posedge clk);
      #1 reset = 0; check_en = 1;
      chk("reset_occ", 64'(occupancy), 64'd0);
      chk("reset_ready", 64'(disp_ready), 64'd1);
      chk("reset_rs0_zero", 64'(rs0_data == '0), 64'd1);

      // Single ready dispatch
      disp(3'd0, 4'd3, 1, 32'd5, 4'd0, 1, 32'd7, 4'd0); tick(); idle();
      chk("t1_valid", 64'(rs0_data.valid_operands), 64'd1);
      chk("t1_rs1", 64'(rs0_data.rs1), 64'd5);
      chk("t1_rs2", 64'(rs0_data.rs2), 64'd7);
      chk("t1_rob", 64'(rs0_data.ROB_entry), 64'd3);
      chk("t1_occ", 64'(occupancy), 64'd1);
      consumed_bus = 4'b0001; #1;
      chk("t1_mask", 64'(rs0_data.valid_operands), 64'd0);
      tick(); idle();
      chk("t1_freed", 64'(occupancy), 64'd0);

      // Fill, hold a fifth, free entry1
      for (int i = 0; i < 4; i++) begin
         disp(3'(i), 4'(i + 1), 1, 32'(i), 4'd0, 1, 32'(i + 100), 4'd0); tick();
      end
      chk("t2_full_ready", 64'(disp_ready), 64'd0);
      disp(3'd5, 4'd10, 1, 32'd55, 4'd0, 1, 32'd66, 4'd0); tick();
      chk("t2_occ_full", 64'(occupancy), 64'd4);
      chk("t2_rob1_kept", 64'(rs1_data.ROB_entry), 64'd2);
      consumed_bus = 4'b0010; #1;
      chk("t2_mask1", 64'(rs1_data.valid_operands), 64'd0);
      tick(); consumed_bus = 4'd0;
      chk("t2_ready_again", 64'(disp_ready), 64'd1);
      chk("t2_occ3", 64'(occupancy), 64'd3);
      tick(); idle();
      chk("t2_fifth_rob", 64'(rs1_data.ROB_entry), 64'd10);
      chk("t2_occ4", 64'(occupancy), 64'd4);
      flush = 1; tick(); idle();

      // Wakeup on rs2
      disp(3'd1, 4'd2, 1, 32'd11, 4'd0, 0, 32'd0, 4'd6); tick(); idle();
      chk("t3_wait", 64'(rs0_data.valid_operands), 64'd0);
      cdb(4'd5, 32'd123); tick(); idle();
      chk("t3_wrong_tag", 64'(rs0_data.valid_operands), 64'd0);
      cdb(4'd6, 32'hDEADBEEF); tick(); idle();
      chk("t3_woken", 64'(rs0_data.valid_operands), 64'd1);
      chk("t3_rs2", 64'(rs0_data.rs2), 64'hDEADBEEF);
      flush = 1; tick(); idle();

      // Three entries woken by one broadcast
      disp(3'd2, 4'd1, 0, 32'd0, 4'd9, 1, 32'd1, 4'd0); tick();
      disp(3'd3, 4'd2, 1, 32'd2, 4'd0, 0, 32'd0, 4'd9); tick();
      disp(3'd4, 4'd3, 0, 32'd0, 4'd9, 0, 32'd0, 4'd9); tick(); idle();
      chk("t4_none_valid", 64'({rs0_data.valid_operands, rs1_data.valid_operands, rs2_data.valid_operands}), 64'd0);
      cdb(4'd9, 32'h99); tick(); idle();
      chk("t4_all_valid", 64'({rs0_data.valid_operands, rs1_data.valid_operands, rs2_data.valid_operands}), 64'h7);
      chk("t4_both_ops", 64'({rs2_data.rs1, rs2_data.rs2}), {32'h99, 32'h99});
      chk("t4_occ3", 64'(occupancy), 64'd3);
      disp(3'd6, 4'd7, 1, 32'd1, 4'd0, 1, 32'd2, 4'd0);
      consumed_bus = 4'b0001; flush = 1; tick(); idle();
      chk("t6_flush_occ", 64'(occupancy), 64'd0);
      chk("t6_flush_valid", 64'({rs0_data.valid_operands, rs1_data.valid_operands,
                                 rs2_data.valid_operands, rs3_data.valid_operands}), 64'd0);

      // Same-cycle dispatch and broadcast
      disp(3'd1, 4'd4, 0, 32'd0, 4'd7, 1, 32'd3, 4'd0);
      cdb(4'd7, 32'h55); tick(); idle();
      chk("t5_bypass", 64'(rs0_data.valid_operands), 64'(BYP));
      disp(3'd2, 4'd5, 0, 32'd0, 4'd8, 1, 32'd3, 4'd0); tick(); idle();
      reset = 1; cdb(4'd8, 32'h77); tick(); reset = 0; idle(); #1;
      chk("t6_reset_occ", 64'(occupancy), 64'd0);
      chk("t6_reset_valid", 64'({rs0_data.valid_operands, rs1_data.valid_operands,
                                 rs2_data.valid_operands, rs3_data.valid_operands}), 64'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int r;
         reset = ($urandom_range(0, 149) == 0);
         flush = ($urandom_range(0, 59) == 0);
         disp(3'($urandom), 4'($urandom), bit'($urandom), $urandom, 4'($urandom),
              bit'($urandom), $urandom, 4'($urandom));
         disp_valid = ($urandom_range(0, 2) != 0);
         cdb_valid = ($urandom_range(0, 1) == 1); cdb_tag = 4'($urandom); cdb_value = $urandom;
         r = $urandom_range(0, 7);
         consumed_bus = (r < 4) ? 4'(1 << r) : 4'd0;
         tick();
      end
      reset = 0; idle(); tick(); tick();
      check_en = 0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/rs_bank.md
Name: rs_bank

Overview:
- Four-entry reservation station bank in the Issue stage, directly upstream of the functional-unit scheduler.
- Accepts renamed instructions from dispatch and holds them until both source operands are available.
- Operand wakeup comes from snooping the common data bus (CDB).
- Presents each entry to the scheduler as an rs_out_t and frees an entry when the scheduler's one-hot consumed_bus marks it.

Parameters:
- XLEN, 32, operand width
- TAG_W, 4, ROB tag width (matches rs_out_t.ROB_entry)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- flush  input  1  mispredict flush; clears all entries
- disp_valid  input  1  dispatch request
- disp_ready  output  1  at least one entry free; dispatch is accepted when disp_valid && disp_ready
- disp_alu_op  input  3  ALU_op encoding as used by the scheduler
- disp_branch_type  input  2  branch type
- disp_rob_entry  input  TAG_W  destination ROB tag
- disp_rs1_rdy, disp_rs2_rdy  input  1 each  operand value already valid
- disp_rs1_val, disp_rs2_val  input  XLEN each  operand value (used when rdy)
- disp_rs1_tag, disp_rs2_tag  input  TAG_W each  producing ROB tag (used when not rdy)
- cdb_valid  input  1  CDB broadcast valid
- cdb_tag  input  TAG_W  broadcast ROB tag
- cdb_value  input  XLEN  broadcast result
- consumed_bus  input  4  one-hot; bit i frees entry i
- rs0_data, rs1_data, rs2_data, rs3_data  output  rs_out_t each  entry contents to scheduler
- occupancy  output  3  number of busy entries, 0..4

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Per-entry state:
  - busy
  - alu_op, branch_type, rob_entry
  - per operand: rdy, val, tag
- Reset values:
  - All busy=0, all stored fields 0.
  - All rsN_data fields 0 (valid_operands=0).
  - disp_ready=1, occupancy=0.
- Allocation:
  - The lowest-index entry with busy=0 is chosen.
  - On an accepted dispatch its fields are loaded and busy=1 at the next edge.
  - disp_ready = ~&busy, computed from registered busy only.
  - An entry freed this cycle is not reusable until the next cycle.
  - A dispatch while full is ignored; no state change.
- Wakeup:
  - Applies to each busy entry operand with rdy=0.
  - If cdb_valid && cdb_tag==tag, capture cdb_value into val and set rdy=1 at the edge.
  - The matched operand becomes visible the next cycle.
  - Both operands of one entry may wake on the same broadcast.
  - Multiple entries may wake on the same broadcast.
- Output mapping, rsN_data:
  - valid_operands = busy & rs1.rdy & rs2.rdy & ~consumed_bus[N].
  - ALU_op, ROB_entry, branch_type, rs1=val1, rs2=val2 are driven from registers.
  - Idle entries drive all fields 0.
  - The ~consumed_bus mask is combinational. It suppresses re-selection during the cycle between the scheduler's grant and the free.
- Free:
  - consumed_bus[i]=1 clears busy[i] at the edge.
  - Asserting consumed_bus[i] on a non-busy entry is ignored.
  - A free takes priority over a same-cycle wakeup of that entry.
- occupancy: registered popcount of busy, updated every edge.
- Flush:
  - Clears all busy at the edge.
  - Has priority over dispatch, wakeup and consume in the same cycle.
  - A flush behaves identically to reset except it is not gated on reset.
- Reset mid-operation: all entries are dropped; no pending wakeups are retained.
- CDB during dispatch (macro absent):
  - The dispatching operand does not snoop the CDB; it stores rdy as given.
  - Dispatch must supply a forwarded value if a producer broadcasts in the dispatch cycle.
- Simultaneous dispatch, free and CDB to different entries: all take effect independently at the same edge.

Optional Feature:
- Macro: RS_DISPATCH_BYPASS_EN
- When defined:
  - A dispatching operand with rdy=0 compares its tag against cdb_tag while cdb_valid is high.
  - On a match it is written with rdy=1 and val=cdb_value in the allocation edge.
- When undefined: the behaviour is as in the last two Behaviour bullets (no bypass).

Test Plan:
- Reset, then dispatch alu_op=000, rob=3, both operands rdy, values 5 and 7. Next cycle rs0_data.valid_operands=1, rs1=5, rs2=7, ROB_entry=3; occupancy=1.
- Dispatch four instructions, with a fifth held on disp_valid. disp_ready=0 after the fourth, and the fifth is not stored. Assert consumed_bus=0010: entry1 is masked that cycle and disp_ready=1 next cycle. The fifth is then allocated to entry1.
- Dispatch with rs2 not ready, tag=6, then broadcast cdb_tag=6, value=0xDEADBEEF. valid_operands is 0 before the broadcast and 1 the cycle after, with rs2=0xDEADBEEF. A broadcast of tag=5 causes no change.
- Two entries waiting on tag 9, plus one entry with both operands on tag 9, then a single broadcast. All three become valid next cycle.
- Dispatch on the same cycle cdb_tag equals the dispatch tag. With RS_DISPATCH_BYPASS_EN the operand is ready next cycle. Without it the operand stays not ready.
- Three busy entries, then assert flush together with disp_valid and consumed_bus=0001. Next cycle occupancy=0 and all valid_operands=0. Reset asserted mid-wakeup gives the same result.
